// File: rtl/nh_window_gen_pkg.sv
// Shared constants for the 3x3 neighbourhood generator feeding max_pool.
// Defaults mirror the CNN feature-map configuration.
package nh_window_gen_pkg;
  localparam int CNN_NN_WIDTH = 16;
  localparam int NH_K         = 3;
  localparam int FM_W         = 8;
  localparam int FM_H         = 8;
endpackage

// File: rtl/nh_window_gen_line_buffer.sv
// One feature-map row store, read-before-write: dout shows the old entry at addr
// during the cycle in which en overwrites it.
module nh_line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/nh_window_gen.sv
// Streaming 3x3 neighbourhood generator: row-major FP16 pixels in, stride-decimated
// 3x3 windows out, packed row-major with the top-left pixel in the MSBs.
module nh_window_gen
  import nh_window_gen_pkg::*;
#(
  parameter int NN_WIDTH = CNN_NN_WIDTH,
  parameter int IMG_W    = FM_W,
  parameter int IMG_H    = FM_H,
  parameter int STRIDE   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ena,
  input  logic [NN_WIDTH-1:0]             pix_in,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [NH_K*NH_K*NN_WIDTH-1:0]   nh_vector,
  output logic                            nh_valid,
  input  logic                            nh_ready,
  output logic                            nh_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [PW-1:0]       col_ph;
  logic [PW-1:0]       row_ph;
  logic                accept;
  logic                emit;
  logic                col_end;
  logic                row_end;
  logic [NN_WIDTH-1:0] lb0_dout;
  logic [NN_WIDTH-1:0] lb1_dout;
  logic [NN_WIDTH-1:0] col_new [NH_K];
  // Only the two older window columns are stored; the newest column is the live input.
  logic [NN_WIDTH-1:0] win_q [NH_K][NH_K-1];
  logic [NH_K*NH_K*NN_WIDTH-1:0] win_next;

  // Handshake: a pixel moves on ena && pix_valid && pix_ready, a window moves on
  // ena && nh_valid && nh_ready; pix_ready depends combinationally on nh_ready.
  assign pix_ready = ena && !reset && (!nh_valid || nh_ready);
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col == CW'(IMG_W - 1));
  assign row_end   = (row == RW'(IMG_H - 1));
  assign emit      = (row >= RW'(2)) && (col >= CW'(2)) && (row_ph == '0) && (col_ph == '0);

  nh_line_buffer #(.WIDTH(NN_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .addr (col),
    .din  (pix_in),
    .dout (lb1_dout)
  );

  nh_line_buffer #(.WIDTH(NN_WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .en   (accept),
    .addr (col),
    .din  (lb1_dout),
    .dout (lb0_dout)
  );

  always_comb begin
    col_new[0] = lb0_dout;
    col_new[1] = lb1_dout;
    col_new[2] = pix_in;
    win_next   = '0;
    for (int i = 0; i < NH_K; i++) begin
      for (int j = 0; j < NH_K; j++) begin
        win_next[(NH_K*NH_K-1-(i*NH_K+j))*NN_WIDTH +: NN_WIDTH] =
          (j < NH_K-1) ? win_q[i][j] : col_new[i];
      end
    end
  end

  // Phase counters hold (col-2) mod STRIDE and (row-2) mod STRIDE for the next pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (col_end) begin
        col    <= '0;
        col_ph <= '0;
        if (row_end) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + RW'(1);
          if (row >= RW'(2)) begin
            row_ph <= (row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + PW'(1);
          end else begin
            row_ph <= '0;
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col >= CW'(2)) begin
          col_ph <= (col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + PW'(1);
        end else begin
          col_ph <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NH_K; i++) begin
        for (int j = 0; j < NH_K-1; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < NH_K; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= col_new[i];
      end
    end
  end

  // A new emission can only coincide with a hand-off, never overwrite a held window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nh_valid  <= 1'b0;
      nh_last   <= 1'b0;
      nh_vector <= '0;
    end else if (accept && emit) begin
      nh_valid  <= 1'b1;
      nh_last   <= col_end && row_end;
      nh_vector <= win_next;
    end else if (ena && nh_ready) begin
      nh_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nh_window_gen.sv
// Bench for nh_window_gen: a 4x4/stride-1 instance (a) and a 5x5/stride-2 instance (b),
// pixel value = base + row-major index, windows checked against an expected queue.
module tb_nh_window_gen;

  localparam int NW = 16;
  localparam int VW = 9 * NW;
  localparam int EW = VW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ena;
  logic [NW-1:0] pix_in_a, pix_in_b;
  logic          pix_valid_a, pix_valid_b;
  logic          pix_ready_a, pix_ready_b;
  logic [VW-1:0] nh_vector_a, nh_vector_b;
  logic          nh_valid_a, nh_valid_b;
  logic          nh_ready_a, nh_ready_b;
  logic          nh_last_a, nh_last_b;

  nh_window_gen #(.NN_WIDTH(NW), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
    .clk(clk), .reset(reset), .ena(ena),
    .pix_in(pix_in_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready_a),
    .nh_vector(nh_vector_a), .nh_valid(nh_valid_a), .nh_ready(nh_ready_a), .nh_last(nh_last_a)
  );

  nh_window_gen #(.NN_WIDTH(NW), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
    .clk(clk), .reset(reset), .ena(ena),
    .pix_in(pix_in_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
    .nh_vector(nh_vector_b), .nh_valid(nh_valid_b), .nh_ready(nh_ready_b), .nh_last(nh_last_b)
  );

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] log_a [8];
  logic [EW-1:0] log_b [8];
  int tests_run = 0;
  int tests_failed = 0;
  int wins_a, wins_b, lasts_a;
  bit acc_a, acc_b;

  function automatic logic [EW-1:0] mk_win(input int base, input int w, input int r,
                                           input int c, input bit last);
    logic [EW-1:0] v;
    v = '0;
    v[EW-1] = last;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(8-(i*3+j))*NW +: NW] = NW'(base + (r-2+i)*w + (c-2+j));
    return v;
  endfunction

  function automatic logic [EW-1:0] lit(input bit last, input int p[9]);
    logic [EW-1:0] v;
    v = '0;
    v[EW-1] = last;
    for (int idx = 0; idx < 9; idx++) v[(8-idx)*NW +: NW] = NW'(p[idx]);
    return v;
  endfunction

  function automatic bit emits(input int r, input int c, input int s);
    return (r >= 2) && (c >= 2) && ((r-2) % s == 0) && ((c-2) % s == 0);
  endfunction

  task automatic chk_win(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One clock: observe hand-offs and accepts at negedge, return #1 after posedge.
  task automatic tick();
    logic [EW-1:0] e;
    @(negedge clk);
    acc_a = ena && pix_valid_a && pix_ready_a;
    acc_b = ena && pix_valid_b && pix_ready_b;
    if (!reset && ena && nh_valid_a && nh_ready_a) begin
      if (exp_q_a.size() == 0) begin
        chk_bit("unexpected_win_a", 1'b1, 1'b0);
      end else begin
        e = exp_q_a.pop_front();
        chk_win("win_a", {nh_last_a, nh_vector_a}, e);
        if (wins_a < 8) log_a[wins_a] = {nh_last_a, nh_vector_a};
        wins_a++;
        if (nh_last_a) lasts_a++;
      end
    end
    if (!reset && ena && nh_valid_b && nh_ready_b) begin
      if (exp_q_b.size() == 0) begin
        chk_bit("unexpected_win_b", 1'b1, 1'b0);
      end else begin
        e = exp_q_b.pop_front();
        chk_win("win_b", {nh_last_b, nh_vector_b}, e);
        if (wins_b < 8) log_b[wins_b] = {nh_last_b, nh_vector_b};
        wins_b++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input int k, input int base);
    int w, s, r, c, n;
    bit acc;
    w = sel ? 5 : 4;
    s = sel ? 2 : 1;
    r = k / w;
    c = k % w;
    n = 0;
    if (sel) begin pix_in_b = NW'(base + k); pix_valid_b = 1'b1; end
    else     begin pix_in_a = NW'(base + k); pix_valid_a = 1'b1; end
    tick();
    acc = sel ? acc_b : acc_a;
    while (!acc && n < 50) begin
      tick();
      acc = sel ? acc_b : acc_a;
      n++;
    end
    chk_bit(sel ? "accept_b" : "accept_a", acc, 1'b1);
    if (sel) pix_valid_b = 1'b0;
    else     pix_valid_a = 1'b0;
    if (acc && emits(r, c, s)) begin
      if (sel) exp_q_b.push_back(mk_win(base, w, r, c, (r == w-1) && (c == w-1)));
      else     exp_q_a.push_back(mk_win(base, w, r, c, (r == w-1) && (c == w-1)));
    end
  endtask

  task automatic frame_a(input int base, input int first, input int last_k,
                         input bit gaps, input int ena_gap_k);
    for (int k = first; k <= last_k; k++) begin
      if (gaps && k != ena_gap_k) repeat ($urandom_range(0, 2)) tick();
      if (k == ena_gap_k) begin
        pix_in_a = NW'(base + k);
        pix_valid_a = 1'b1;
        ena = 1'b0;
        repeat (3) begin
          tick();
          chk_bit("ena_low_ready", pix_ready_a, 1'b0);
          chk_bit("ena_low_valid_held", nh_valid_a, 1'b1);
        end
        ena = 1'b1;
      end
      send(1'b0, k, base);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || nh_valid_a || nh_valid_b) && n < 40) begin
      tick();
      n++;
    end
    chk_int("drain_queue_a", exp_q_a.size(), 0);
    chk_int("drain_queue_b", exp_q_b.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    ena = 1'b0;
    pix_in_a = '0; pix_in_b = '0;
    pix_valid_a = 1'b0; pix_valid_b = 1'b0;
    nh_ready_a = 1'b1; nh_ready_b = 1'b1;
    #2;
    chk_bit("reset_valid", nh_valid_a, 1'b0);
    chk_bit("reset_last", nh_last_a, 1'b0);
    chk_win("reset_vector", {1'b0, nh_vector_a}, '0);
    chk_bit("reset_pix_ready", pix_ready_a, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ena = 1'b1;
    tick();

    // 1: 4x4 stride 1, continuous stream
    wins_a = 0; lasts_a = 0;
    frame_a(0, 0, 15, 1'b0, -1);
    drain();
    chk_int("s1_count", wins_a, 4);
    chk_int("s1_lasts", lasts_a, 1);
    chk_win("s1_first", log_a[0], lit(1'b0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    chk_win("s1_last", log_a[3], lit(1'b1, '{5, 6, 7, 9, 10, 11, 13, 14, 15}));

    // 2: 5x5 stride 2
    wins_b = 0;
    for (int k = 0; k < 25; k++) send(1'b1, k, 0);
    drain();
    chk_int("s2_count", wins_b, 4);
    chk_win("s2_win_k14", log_b[1], lit(1'b0, '{2, 3, 4, 7, 8, 9, 12, 13, 14}));
    chk_bit("s2_last_flag", log_b[3][EW-1], 1'b1);

    // 3: back-pressure after the first window
    wins_a = 0; lasts_a = 0;
    frame_a(0, 0, 10, 1'b0, -1);
    nh_ready_a = 1'b0;
    pix_in_a = NW'(11);
    pix_valid_a = 1'b1;
    repeat (4) begin
      tick();
      chk_bit("bp_pix_ready", pix_ready_a, 1'b0);
      chk_bit("bp_valid", nh_valid_a, 1'b1);
      chk_win("bp_vector", {nh_last_a, nh_vector_a}, lit(1'b0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    end
    nh_ready_a = 1'b1;
    frame_a(0, 11, 15, 1'b0, -1);
    drain();
    chk_int("s3_count", wins_a, 4);

    // 4: ena low for 3 cycles mid-row plus random valid gaps
    wins_a = 0; lasts_a = 0;
    frame_a(0, 0, 15, 1'b1, 11);
    drain();
    chk_int("s4_count", wins_a, 4);
    chk_int("s4_lasts", lasts_a, 1);

    // 5: reset in the middle of a frame, then a clean frame
    wins_a = 0; lasts_a = 0;
    frame_a(0, 0, 9, 1'b0, -1);
    reset = 1'b1;
    tick();
    chk_bit("midreset_valid", nh_valid_a, 1'b0);
    chk_bit("midreset_pix_ready", pix_ready_a, 1'b0);
    chk_win("midreset_vector", {nh_last_a, nh_vector_a}, '0);
    reset = 1'b0;
    frame_a(0, 0, 15, 1'b0, -1);
    drain();
    chk_int("s5_count", wins_a, 4);
    chk_win("s5_first", log_a[0], lit(1'b0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}));

    // 6: two back-to-back frames, the second offset by 100
    wins_a = 0; lasts_a = 0;
    frame_a(0, 0, 15, 1'b0, -1);
    frame_a(100, 0, 15, 1'b0, -1);
    drain();
    chk_int("s6_count", wins_a, 8);
    chk_int("s6_lasts", lasts_a, 2);
    chk_bit("s6_last_4th", log_a[3][EW-1], 1'b1);
    chk_bit("s6_last_8th", log_a[7][EW-1], 1'b1);
    chk_win("s6_frame2_first", log_a[4],
            lit(1'b0, '{100, 101, 102, 104, 105, 106, 108, 109, 110}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
